// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, start-of-frame byte, memory geometry and the running checksum
// helper used when the checksum trailer is built in.
// ----------------------------------------------------------------------------
package imem_pkg;

  localparam int         IMEM_DEPTH_WORDS = 64;
  localparam int         IMEM_AW          = 6;
  localparam int         IMEM_WORD_W      = 32;
  localparam logic [7:0] IMEM_SOF         = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERR   = 3'd6
  } imem_state_e;

  // Modulo-256 accumulation; a frame is good when the total including the
  // trailer byte comes back to zero.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// ----------------------------------------------------------------------------
// imem_byte_packer
// Packs bytes MSB-first into a 32-bit word. The first byte of a word ends up
// in [31:24] once four bytes have been shifted in.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear        restart packing (byte counter and word to zero)
//   shift        shift byte_in into the word this cycle
//   byte_in      byte to shift in
//   word_ready   this shift completes a word (4th byte of the group)
//   word         packed word register (valid the cycle after word_ready)
// ----------------------------------------------------------------------------
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   shift,
  input  logic [7:0]             byte_in,
  output logic                   word_ready,
  output logic [IMEM_WORD_W-1:0] word
);

  logic [1:0]             cnt_q, cnt_d;
  logic [IMEM_WORD_W-1:0] word_q, word_d;

  // Next byte count and shift-register contents.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = 2'd0;
      word_d = 32'd0;
    end else if (shift) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {word_q[23:0], byte_in};
    end else begin
      cnt_d  = cnt_q;
      word_d = word_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_ready = shift & (cnt_q == 2'd3);
  assign word       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
// Byte-serial boot controller for the 64-word instruction memory. Frame:
// SOF (8'hFE), length N (1..DEPTH_WORDS), N big-endian 32-bit words and,
// when IMEM_LOADER_CHECKSUM_EN is defined, one trailer byte C with
// (N + sum(data) + C) mod 256 == 0. Keeps the CPU held while loading or
// after a failed frame.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rx_data/valid/ready byte input handshake (accept on valid && ready)
//   mem_we/waddr/wdata  one-cycle word write to instruction memory
//   cpu_hold            CPU stall / reset request
//   load_done/load_err  status of the last frame
//   words_loaded        words written by the current or last frame
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
// ----------------------------------------------------------------------------
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int AW          = IMEM_AW
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_waddr,
  output logic [IMEM_WORD_W-1:0] mem_wdata,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_err,
  output logic [AW:0]            words_loaded
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH_WORDS);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  imem_state_e   state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   word_cnt_q, word_cnt_d;
  logic          rx_ready_q, rx_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q, load_err_d;
  logic [AW:0]   words_loaded_q, words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic accept_s;
  logic pk_clear_s, pk_shift_s, pk_ready_s;

  assign accept_s = rx_valid & rx_ready_q;

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear_s),
    .shift      (pk_shift_s),
    .byte_in    (rx_data),
    .word_ready (pk_ready_s),
    .word       (mem_wdata)
  );

  // Frame FSM: next state and next values of all registered outputs.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    word_cnt_d     = word_cnt_q;
    rx_ready_d     = 1'b1;
    mem_we_d       = 1'b0;
    mem_waddr_d    = mem_waddr_q;
    cpu_hold_d     = cpu_hold_q;
    load_done_d    = load_done_q;
    load_err_d     = load_err_q;
    words_loaded_d = words_loaded_q;
    pk_clear_s     = 1'b0;
    pk_shift_s     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (rx_data == IMEM_SOF)) begin
          state_d        = ST_LEN;
          words_loaded_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (!accept_s) begin
          state_d = ST_LEN;
        end else if ((rx_data == 8'd0) || (rx_data > DEPTH_B)) begin
          state_d    = ST_ERR;
          load_err_d = 1'b1;
          cpu_hold_d = 1'b1;
        end else begin
          state_d    = ST_DATA;
          len_d      = rx_data[AW:0];
          word_cnt_d = '0;
          pk_clear_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = rx_data;
`endif
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          pk_shift_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = csum_add(sum_q, rx_data);
`endif
          // The 4th byte lands in the packer on this edge, so the write
          // strobe and address are registered together with it.
          if (pk_ready_s) begin
            state_d     = ST_WRITE;
            mem_we_d    = 1'b1;
            mem_waddr_d = word_cnt_q[AW-1:0];
            rx_ready_d  = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        word_cnt_d     = word_cnt_q + CNT_ONE;
        words_loaded_d = word_cnt_q + CNT_ONE;
        if ((word_cnt_q + CNT_ONE) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d     = ST_CSUM;
`else
          state_d     = ST_RUN;
          cpu_hold_d  = 1'b0;
          load_done_d = 1'b1;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (!accept_s) begin
          state_d = ST_CSUM;
        end else if (csum_add(sum_q, rx_data) == 8'h00) begin
          state_d     = ST_RUN;
          cpu_hold_d  = 1'b0;
          load_done_d = 1'b1;
        end else begin
          state_d    = ST_ERR;
          load_err_d = 1'b1;
          cpu_hold_d = 1'b1;
        end
      end
`endif
      ST_RUN: begin
        if (accept_s && (rx_data == IMEM_SOF)) begin
          state_d        = ST_LEN;
          cpu_hold_d     = 1'b1;
          load_done_d    = 1'b0;
          words_loaded_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ERR: begin
        if (accept_s && (rx_data == IMEM_SOF)) begin
          state_d        = ST_LEN;
          load_err_d     = 1'b0;
          words_loaded_d = '0;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      word_cnt_q     <= '0;
      rx_ready_q     <= 1'b1;
      mem_we_q       <= 1'b0;
      mem_waddr_q    <= '0;
      cpu_hold_q     <= 1'b1;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q          <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      word_cnt_q     <= word_cnt_d;
      rx_ready_q     <= rx_ready_d;
      mem_we_q       <= mem_we_d;
      mem_waddr_q    <= mem_waddr_d;
      cpu_hold_q     <= cpu_hold_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
      words_loaded_q <= words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_boot_loader
// Scoreboard bench: every expected memory write is queued as its last byte is
// driven and popped when mem_we is seen. Status outputs are compared against
// constants after each frame. Define IMEM_LOADER_CHECKSUM_EN to exercise the
// checksum trailer.
// ----------------------------------------------------------------------------
module tb_imem_boot_loader;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [6:0]  words_loaded;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt = 0;
  bit          gap_en = 1'b0;
  wr_t         sb_q[$];
  logic [31:0] words [64];

  imem_boot_loader dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: pop the scoreboard on every strobe.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      wr_cnt++;
      check("wr_rx_ready_low", {31'd0, rx_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", {26'd0, mem_waddr}, {26'd0, e.addr});
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  // Called and returns at a falling edge; byte is accepted on the rising
  // edge following a falling edge that sees rx_ready high.
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n, input int nw, input bit sof,
                            input bit trailer, input bit bad_csum);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] w;
    sum = n;
    if (sof) send_byte(8'hFE);
    send_byte(n);
    for (int i = 0; i < nw; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        b   = w[31-8*j -: 8];
        sum = sum + b;
        if (j == 3) sb_q.push_back('{addr: 6'(i), data: w});
        send_byte(b);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (trailer) begin
      b = 8'h00 - sum;
      if (bad_csum) b = b + 8'h01;
      send_byte(b);
    end
`else
    if (trailer && bad_csum) b = 8'h00;
`endif
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done,
                              input logic err, input logic [6:0] wl);
    check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
    check({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, "_err"},  {31'd0, load_err},  {31'd0, err});
    check({tag, "_wl"},   {25'd0, words_loaded}, {25'd0, wl});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    check({tag, "_mem_we"},   {31'd0, mem_we}, 32'd0);
    check({tag, "_waddr"},    {26'd0, mem_waddr}, 32'd0);
    check({tag, "_wdata"},    mem_wdata, 32'd0);
    check_status(tag, 1'b1, 1'b0, 1'b0, 7'd0);
  endtask

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // 1: single word frame
    words[0] = 32'h12345678;
    c0 = wr_cnt;
    send_frame(8'h01, 1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_status("t1", 1'b0, 1'b1, 1'b0, 7'd1);
    check("t1_wr_cnt", 32'(wr_cnt - c0), 32'd1);

    // 5: reload from RUN drops done and raises hold on the SOF edge
    send_byte(8'hFE);
    check_status("t5_sof", 1'b1, 1'b0, 1'b0, 7'd0);
    words[0] = 32'hFEFF_0102;
    words[1] = 32'hA5A5_5A5A;
    send_frame(8'h02, 2, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_status("t5_end", 1'b0, 1'b1, 1'b0, 7'd2);

    // 2: full-depth frame with random rx_valid gaps
    gap_en = 1'b1;
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    c0 = wr_cnt;
    send_frame(8'h40, 64, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_status("t2", 1'b0, 1'b1, 1'b0, 7'd64);
    check("t2_wr_cnt", 32'(wr_cnt - c0), 32'd64);
    gap_en = 1'b0;

    // 3: illegal lengths, then a good frame clears the error
    c0 = wr_cnt;
    send_byte(8'hFE);
    send_byte(8'h00);
    check_status("t3_len0", 1'b1, 1'b0, 1'b1, 7'd0);
    send_byte(8'h11);
    check("t3_err_hold", {31'd0, load_err}, 32'd1);
    send_byte(8'hFE);
    check("t3_err_clr", {31'd0, load_err}, 32'd0);
    send_byte(8'h41);
    check_status("t3_len65", 1'b1, 1'b0, 1'b1, 7'd0);
    repeat (3) @(negedge clk);
    check("t3_no_wr", 32'(wr_cnt - c0), 32'd0);
    words[0] = 32'hCAFE_F00D;
    send_frame(8'h01, 1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_status("t3_ok", 1'b0, 1'b1, 1'b0, 7'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 4: checksum mismatch then match
    sb_q.push_back('{addr: 6'd0, data: 32'h0000_0001});
    send_byte(8'hFE); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    check_status("t4_bad", 1'b1, 1'b0, 1'b1, 7'd1);
    sb_q.push_back('{addr: 6'd0, data: 32'h0000_0001});
    send_byte(8'hFE); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hFE);
    repeat (2) @(negedge clk);
    check_status("t4_good", 1'b0, 1'b1, 1'b0, 7'd1);
`endif

    // 6: reset mid-frame after two bytes of word 3
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    send_frame(8'h08, 3, 1'b1, 1'b0, 1'b0);
    send_byte(8'h3C);
    send_byte(8'hC3);
    check("t6_wl_pre", {25'd0, words_loaded}, 32'd3);
    #2 reset = 1'b1;
    @(negedge clk);
    check_reset_vals("t6_rst");
    reset = 1'b0;
    @(negedge clk);
    words[0] = 32'h0BAD_BEEF;
    send_frame(8'h01, 1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_status("t6_ok", 1'b0, 1'b1, 1'b0, 7'd1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
